// File: rtl/dtc_level_window.sv
// dtc_level_window
//   Converts the decision-tree classifier's thermometer-coded output into a
//   binary level, flags malformed codes, and aggregates levels over a window
//   of 2^LOG2_WINDOW accepted samples. One registered statistics record is
//   produced per window (or per flushed partial window).
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready depends only on out_valid/out_ready
//   in_code             thermometer code, ones filled from the LSB upward
//   flush               close a partial window (honoured only while in_ready=1)
//   out_valid/out_ready output handshake; record held stable while stalled
//   out_sum             sum of levels in the window
//   out_mean            (out_sum + WINDOW/2) >> LOG2_WINDOW, always over WINDOW
//   out_min, out_max    extreme levels in the window
//   out_count           samples in the window (1..WINDOW)
//   out_err             at least one malformed code in the window
//   err_total           saturating count of malformed codes since reset
module dtc_level_window #(
    parameter int WIDTH       = 12,
    parameter int LOG2_WINDOW = 3,
    parameter int LW          = $clog2(WIDTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_code,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LW+LOG2_WINDOW-1:0] out_sum,
    output logic [LW-1:0]             out_mean,
    output logic [LW-1:0]             out_min,
    output logic [LW-1:0]             out_max,
    output logic [LOG2_WINDOW:0]      out_count,
    output logic                      out_err,
    output logic [15:0]               err_total
);

    localparam int WINDOW = 1 << LOG2_WINDOW;
    localparam int SW     = LW + LOG2_WINDOW;
    localparam int CW     = LOG2_WINDOW + 1;

    // Length of the run of ones starting at bit 0.
    function automatic logic [LW-1:0] therm_level(input logic [WIDTH-1:0] c);
        logic [LW-1:0] n;
        logic          run;
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (run && c[i]) n = n + LW'(1);
            else             run = 1'b0;
        end
        return n;
    endfunction

    // A one anywhere above the first zero makes the code malformed.
    function automatic logic therm_malformed(input logic [WIDTH-1:0] c);
        logic seen_zero;
        logic bad;
        seen_zero = 1'b0;
        bad       = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!c[i])          seen_zero = 1'b1;
            else if (seen_zero) bad       = 1'b1;
        end
        return bad;
    endfunction

    // Round-half-up division by WINDOW; the extra MSB keeps the carry of the
    // rounding constant.
    function automatic logic [LW-1:0] round_mean(input logic [SW-1:0] s);
        return LW'(({1'b0, s} + (SW+1)'(WINDOW / 2)) >> LOG2_WINDOW);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic inc);
        return (inc && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    logic [SW-1:0] acc_sum;
    logic [LW-1:0] acc_min;
    logic [LW-1:0] acc_max;
    logic [CW-1:0] acc_cnt;
    logic          acc_err;

    logic          vld_p0;
    logic [LW-1:0] lvl_p0;
    logic          bad_p0;
    logic [SW-1:0] sum_p0;
    logic [LW-1:0] min_p0;
    logic [LW-1:0] max_p0;
    logic [CW-1:0] cnt_p0;
    logic          err_p0;
    logic          close_p0;

    // Stall input only while a record is waiting on the consumer.
    assign in_ready = !(out_valid && !out_ready);

    // Stage p0: decode the code and form the window totals including the
    // current sample, so a closing sample lands in its own record.
    always_comb begin
        vld_p0   = in_valid && in_ready;
        lvl_p0   = therm_level(in_code);
        bad_p0   = therm_malformed(in_code);
        sum_p0   = acc_sum + (vld_p0 ? SW'(lvl_p0) : '0);
        min_p0   = (vld_p0 && lvl_p0 < acc_min) ? lvl_p0 : acc_min;
        max_p0   = (vld_p0 && lvl_p0 > acc_max) ? lvl_p0 : acc_max;
        cnt_p0   = acc_cnt + CW'(vld_p0);
        err_p0   = acc_err | (vld_p0 & bad_p0);
        // cnt_p0 != 0 covers both "window non-empty" and "sample this cycle".
        close_p0 = (vld_p0 && cnt_p0 == CW'(WINDOW)) ||
                   (flush && in_ready && cnt_p0 != '0);
    end

    // Stage p1: accumulators and the registered output record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sum   <= '0;
            acc_min   <= LW'(WIDTH);
            acc_max   <= '0;
            acc_cnt   <= '0;
            acc_err   <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_mean  <= '0;
            out_min   <= '0;
            out_max   <= '0;
            out_count <= '0;
            out_err   <= 1'b0;
            err_total <= '0;
        end else begin
            err_total <= sat_inc16(err_total, vld_p0 && bad_p0);
            if (close_p0) begin
                out_valid <= 1'b1;
                out_sum   <= sum_p0;
                out_mean  <= round_mean(sum_p0);
                out_min   <= min_p0;
                out_max   <= max_p0;
                out_count <= cnt_p0;
                out_err   <= err_p0;
                acc_sum   <= '0;
                acc_min   <= LW'(WIDTH);
                acc_max   <= '0;
                acc_cnt   <= '0;
                acc_err   <= 1'b0;
            end else begin
                if (vld_p0) begin
                    acc_sum <= sum_p0;
                    acc_min <= min_p0;
                    acc_max <= max_p0;
                    acc_cnt <= cnt_p0;
                    acc_err <= err_p0;
                end
                if (out_valid && out_ready) out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dtc_level_window.sv
module tb_dtc_level_window;

    localparam int WIDTH       = 12;
    localparam int LOG2_WINDOW = 3;
    localparam int LW          = 4;
    localparam int WINDOW      = 8;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic [11:0] in_code   = '0;
    logic        flush     = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic        out_valid;
    logic [6:0]  out_sum;
    logic [3:0]  out_mean;
    logic [3:0]  out_min;
    logic [3:0]  out_max;
    logic [3:0]  out_count;
    logic        out_err;
    logic [15:0] err_total;

    dtc_level_window #(.WIDTH(WIDTH), .LOG2_WINDOW(LOG2_WINDOW), .LW(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_mean(out_mean), .out_min(out_min),
        .out_max(out_max), .out_count(out_count), .out_err(out_err),
        .err_total(err_total)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int ref_level(input logic [11:0] c);
        int l = 0;
        while (l < WIDTH && c[l] == 1'b1) l++;
        return l;
    endfunction

    // Well-formed thermometer codes are exactly 2^k-1.
    function automatic bit ref_bad(input logic [11:0] c);
        int v = int'(c);
        return ((v + 1) & v) != 0;
    endfunction

    int q_lvl[$];
    bit q_bad[$];
    bit m_valid;
    int m_sum, m_mean, m_min, m_max, m_cnt, m_errtot;
    bit m_err, m_rdy, m_acc, m_hs;

    always @(posedge clk or negedge rst_n) begin : model
        if (!rst_n) begin
            q_lvl.delete(); q_bad.delete();
            m_valid = 0; m_sum = 0; m_mean = 0; m_min = 0; m_max = 0;
            m_cnt = 0; m_err = 0; m_errtot = 0;
        end else begin
            m_rdy = !(m_valid && !out_ready);
            m_acc = in_valid && m_rdy;
            m_hs  = m_valid && out_ready;
            if (m_acc) begin
                q_lvl.push_back(ref_level(in_code));
                q_bad.push_back(ref_bad(in_code));
                if (ref_bad(in_code) && m_errtot < 65535) m_errtot++;
            end
            if (q_lvl.size() == WINDOW || (flush && m_rdy && q_lvl.size() > 0)) begin
                m_sum = 0; m_min = WIDTH; m_max = 0; m_err = 0;
                foreach (q_lvl[i]) begin
                    m_sum += q_lvl[i];
                    if (q_lvl[i] < m_min) m_min = q_lvl[i];
                    if (q_lvl[i] > m_max) m_max = q_lvl[i];
                    if (q_bad[i]) m_err = 1;
                end
                m_cnt   = q_lvl.size();
                m_mean  = (m_sum + WINDOW / 2) / WINDOW;
                m_valid = 1;
                q_lvl.delete(); q_bad.delete();
            end else if (m_hs) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        cmp("in_ready",  in_ready,  !(m_valid && !out_ready));
        cmp("out_valid", out_valid, m_valid);
        cmp("out_sum",   out_sum,   m_sum);
        cmp("out_mean",  out_mean,  m_mean);
        cmp("out_min",   out_min,   m_min);
        cmp("out_max",   out_max,   m_max);
        cmp("out_count", out_count, m_cnt);
        cmp("out_err",   out_err,   m_err);
        cmp("err_total", err_total, m_errtot);
    end

    // ---------------- stimulus ----------------
    // All tasks start and end just after a rising edge.
    task automatic send(input logic [11:0] c);
        bit took = 0;
        in_valid = 1'b1;
        in_code  = c;
        for (int n = 0; n < 50 && !took; n++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk); #1;
        end
        if (!took) cmp("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic chk_rec(input string nm, input int s, input int mn, input int lo,
                           input int hi, input int cnt, input int e);
        @(negedge clk);
        cmp({nm, ".valid"}, out_valid, 1);
        cmp({nm, ".sum"},   out_sum,   s);
        cmp({nm, ".mean"},  out_mean,  mn);
        cmp({nm, ".min"},   out_min,   lo);
        cmp({nm, ".max"},   out_max,   hi);
        cmp({nm, ".count"}, out_count, cnt);
        cmp({nm, ".err"},   out_err,   e);
        @(posedge clk); #1;
    endtask

    task automatic chk_zero(input string nm);
        cmp({nm, ".valid"}, out_valid, 0);
        cmp({nm, ".sum"},   out_sum,   0);
        cmp({nm, ".mean"},  out_mean,  0);
        cmp({nm, ".min"},   out_min,   0);
        cmp({nm, ".max"},   out_max,   0);
        cmp({nm, ".count"}, out_count, 0);
        cmp({nm, ".err"},   out_err,   0);
        cmp({nm, ".etot"},  err_total, 0);
        cmp({nm, ".ready"}, in_ready,  1);
    endtask

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full window of level 8.
        for (int i = 0; i < 8; i++) send(12'h0FF);
        chk_rec("full8", 64, 8, 8, 8, 8, 0);

        // Levels 0..7.
        for (int i = 0; i < 8; i++) send(12'((1 << i) - 1));
        chk_rec("ramp", 28, 4, 0, 7, 8, 0);

        // One malformed code, then a clean window.
        send(12'h0F5);
        for (int i = 0; i < 7; i++) send(12'h003);
        chk_rec("bad", 15, 2, 1, 2, 8, 1);
        cmp("bad.etot", err_total, 1);
        for (int i = 0; i < 8; i++) send(12'h003);
        chk_rec("clean", 16, 2, 2, 2, 8, 0);
        cmp("clean.etot", err_total, 1);

        // Backpressure; flush held while stalled is ignored, then the
        // releasing edge both consumes the record and closes a 1-sample window.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(12'h001);
        in_valid = 1'b1; in_code = 12'h003; flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmp("stall.ready", in_ready,  0);
            cmp("stall.valid", out_valid, 1);
            cmp("stall.sum",   out_sum,   8);
            cmp("stall.mean",  out_mean,  1);
            cmp("stall.count", out_count, 8);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        cmp("release.ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk_rec("coincide", 2, 0, 2, 2, 1, 0);
        @(negedge clk);
        cmp("consumed.valid", out_valid, 0);
        @(posedge clk); #1;

        // Partial window by flush, then flush on an empty window.
        for (int i = 0; i < 3; i++) send(12'hFFF);
        do_flush();
        chk_rec("flush3", 36, 5, 12, 12, 3, 0);
        do_flush();
        @(negedge clk);
        cmp("emptyflush.valid", out_valid, 0);
        @(posedge clk); #1;

        // Reset mid-window discards the partial window.
        for (int i = 0; i < 4; i++) send(12'h007);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 7; i++) send(12'h001);
        @(negedge clk);
        cmp("after_rst7.valid", out_valid, 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(12'h001);
        chk_rec("after_rst8", 8, 1, 1, 1, 8, 0);

        // Reset with a record pending.
        rst_n = 1'b0;
        #1;
        chk_zero("rst_pend");
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // err_total saturation.
        in_valid = 1'b1; in_code = 12'h0F5;
        repeat (65535) @(posedge clk);
        #1;
        cmp("sat.65535", err_total, 16'hFFFF);
        @(posedge clk); #1;
        cmp("sat.65536", err_total, 16'hFFFF);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dtc_level_window.md
Name: dtc_level_window

Overview:
- Sits directly downstream of the decision-tree classifier stage.
- Consumes its 12-bit thermometer-coded output, one word per accepted sample.
- Converts each word to a binary level and checks that the code is well formed.
- Aggregates levels over a window of 2^LOG2_WINDOW samples and emits one registered statistics record per window, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 12, thermometer code width; level range 0..WIDTH.
- LOG2_WINDOW, 3, log2 of window length (range 1..8); WINDOW = 2^LOG2_WINDOW.
- LW, 4, level width = clog2(WIDTH+1).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_code is valid.
- in_ready  output  1  block accepts in_code this cycle.
- in_code  input  WIDTH  thermometer code; ones are filled from the LSB upward.
- flush  input  1  close a partial window.
- out_valid  output  1  statistics record is valid.
- out_ready  input  1  consumer takes the record.
- out_sum  output  LW+LOG2_WINDOW  sum of levels in the window.
- out_mean  output  LW  (out_sum + WINDOW/2) >> LOG2_WINDOW.
- out_min  output  LW  minimum level in the window.
- out_max  output  LW  maximum level in the window.
- out_count  output  LOG2_WINDOW+1  number of samples in the window (1..WINDOW).
- out_err  output  1  at least one malformed code in the window.
- err_total  output  16  saturating count of malformed codes since reset.

Behaviour:
- Accept: a sample is accepted when in_valid && in_ready.
  - in_ready = !(out_valid && !out_ready), combinational from out_valid and out_ready.
- Level: number of consecutive ones starting at bit 0, up to the first zero.
  - Malformed: any 1 above that first zero.
  - Example: 0x0F5 gives level 1, malformed.
  - 0x000 gives level 0; 0xFFF gives level 12; both are well formed.
- Accumulators:
  - acc_sum, acc_min (initialised to WIDTH), acc_max (initialised to 0), acc_cnt, acc_err.
  - Each accepted sample updates all of them.
- Window close happens when either:
  - the accepted sample makes acc_cnt == WINDOW, or
  - flush=1 and in_ready=1 and (acc_cnt>0 or a sample is accepted in the same cycle). The concurrent sample is included in the closed window.
- On close:
  - Output registers load the final values including the closing sample; out_valid is set on the same edge.
  - Accumulators return to their initial values on the same edge.
  - Latency: the last sample is accepted at edge N; the record is visible after edge N.
- No-op cases:
  - flush with an empty window and no accepted sample: no record.
  - flush while in_ready=0: ignored. The producer holds flush until in_ready=1.
- Mean: out_mean always divides by WINDOW, including for partial (flushed) windows. Consumers use out_count to interpret partial windows.
- Output hold: while out_valid && !out_ready, all out_* fields are stable.
- out_valid clears on a handshake edge unless a new window closes on that same edge.
  - A close can coincide with the handshake because in_ready=1 when out_ready=1.
  - In that case the new record loads and out_valid stays 1.
- err_total: +1 per accepted malformed sample, saturating at 0xFFFF; cleared only by reset.
- Widths: out_sum cannot overflow, since WINDOW*WIDTH fits in LW+LOG2_WINDOW bits.
- Reset (asynchronous, any time, including mid-window or with a record pending):
  - All outputs become 0; in_ready then follows its equation.
  - Accumulators return to their initial values; the partial window is discarded.
  - err_total becomes 0.
- No combinational path from in_code or in_valid to any output.

Test Plan:
- 8x in_code=0x0FF, out_ready=1 -> one record: out_sum=64, out_mean=8, out_min=out_max=8, out_count=8, out_err=0; visible the cycle after the 8th accept.
- Codes 0x000,0x001,0x003,...,0x07F (levels 0..7) -> out_sum=28, out_mean=4, out_min=0, out_max=7, out_count=8.
- Window containing one 0x0F5 among seven 0x003 -> that sample counts as level 1; out_sum=15, out_min=1, out_max=2, out_err=1, err_total=1. The next clean window has out_err=0 and err_total stays 1.
- Record pending, out_ready=0 for 5 cycles, in_valid=1 -> in_ready=0 and outputs stable throughout. Raise out_ready -> record consumed and the next sample accepted that cycle. A close coinciding with the handshake keeps out_valid=1 with the new data.
- 3x 0xFFF then flush=1 -> out_count=3, out_sum=36, out_mean=5, out_min=out_max=12. flush on an empty window -> no record.
- rst_n low after 4 accepted samples and with a record pending -> all outputs 0 immediately. After release, a full 8-sample window is needed for the next record; err_total saturation checked by forcing 65536 malformed samples -> holds at 0xFFFF.
